// File: rtl/conv3x3_prog_filter_if.sv
// Window/kernel-load bus for the programmable 3x3 convolution stage.
// The master drives windows and coefficient writes; the slave returns the filtered pixel.
interface conv3x3_prog_filter_if #(
   parameter int PIX_W   = 4,
   parameter int COEF_W  = 4,
   parameter int SHIFT_W = 4
);
   logic                 i_valid;
   logic [9*PIX_W-1:0]   i_pixels;
   logic [1:0]           i_mode;
   logic [SHIFT_W-1:0]   i_shift;
   logic                 i_coef_we;
   logic [3:0]           i_coef_addr;
   logic [COEF_W-1:0]    i_coef_data;
   logic                 i_coef_commit;
   logic                 o_valid;
   logic [PIX_W-1:0]     o_pixel;
   logic                 o_sat;

   modport master (
      output i_valid, i_pixels, i_mode, i_shift,
      output i_coef_we, i_coef_addr, i_coef_data, i_coef_commit,
      input  o_valid, o_pixel, o_sat
   );

   modport slave (
      input  i_valid, i_pixels, i_mode, i_shift,
      input  i_coef_we, i_coef_addr, i_coef_data, i_coef_commit,
      output o_valid, o_pixel, o_sat
   );
endinterface

// File: rtl/conv3x3_prog_filter.sv
// Programmable signed 3x3 convolution with shadow/active kernel banks and
// shift / mean-of-9 / abs-shift normalisation; 4-stage pipeline, clamped output.
module conv3x3_prog_filter #(
   parameter int PIX_W   = 4,
   parameter int COEF_W  = 4,
   parameter int ACC_W   = PIX_W + COEF_W + 4,
   parameter int SHIFT_W = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   conv3x3_prog_filter_if.slave bus
);
   localparam int PROD_W = PIX_W + COEF_W + 1;
   localparam int RES_W  = ACC_W + 2;
   localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((1 << PIX_W) - 1);

   logic signed [COEF_W-1:0] shadow [9];
   logic signed [COEF_W-1:0] active [9];
   logic [2:0]               vld_pipe;
   logic signed [PROD_W-1:0] prod [9];
   logic signed [ACC_W-1:0]  row [3];
   logic signed [ACC_W-1:0]  sum;
   logic [1:0]               mode1, mode2, mode3;
   logic [SHIFT_W-1:0]       shift1, shift2, shift3;

   // A write in the commit cycle is forwarded straight into the active bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 9; k++) begin
            shadow[k] <= COEF_W'(1);
            active[k] <= COEF_W'(1);
         end
      end else begin
         for (int k = 0; k < 9; k++) begin
            if (bus.i_coef_we && bus.i_coef_addr == 4'(k))
               shadow[k] <= bus.i_coef_data;
            if (bus.i_coef_commit)
               active[k] <= (bus.i_coef_we && bus.i_coef_addr == 4'(k)) ? bus.i_coef_data : shadow[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_pipe <= '0;
      else          vld_pipe <= {vld_pipe[1:0], bus.i_valid};
   end

   // Datapath carries mode/shift alongside each window so reprogramming never disturbs in-flight data.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 9; k++)
         prod[k] <= PROD_W'($signed({1'b0, bus.i_pixels[k*PIX_W +: PIX_W]})) * PROD_W'(active[k]);
      mode1  <= bus.i_mode;
      shift1 <= bus.i_shift;
      for (int r = 0; r < 3; r++)
         row[r] <= ACC_W'(prod[3*r]) + ACC_W'(prod[3*r+1]) + ACC_W'(prod[3*r+2]);
      mode2  <= mode1;
      shift2 <= shift1;
      sum    <= row[0] + row[1] + row[2];
      mode3  <= mode2;
      shift3 <= shift2;
   end

   logic signed [ACC_W:0]   sx;
   logic [ACC_W:0]          mag;
   logic [ACC_W-1:0]        quo;
   logic signed [RES_W-1:0] res;
   logic [PIX_W-1:0]        pix_n;
   logic                    sat_n;

   // Magnitude is one bit wider than the sum so the most-negative value cannot wrap.
   always_comb begin
      sx    = (ACC_W+1)'(sum);
      mag   = sum[ACC_W-1] ? $unsigned(-sx) : $unsigned(sx);
      quo   = sum[ACC_W-1] ? '0 : $unsigned(sum) / ACC_W'(9);
      case (mode3)
         2'd0:    res = RES_W'(sx >>> shift3);
         2'd2:    res = $signed({1'b0, mag >> shift3});
         default: res = $signed({2'b00, quo});
      endcase
      pix_n = res[PIX_W-1:0];
      sat_n = 1'b0;
      if (res < 0) begin
         pix_n = '0;
         sat_n = 1'b1;
      end else if (res > PIX_MAX) begin
         pix_n = '1;
         sat_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.o_valid <= 1'b0;
         bus.o_pixel <= '0;
         bus.o_sat   <= 1'b0;
      end else begin
         bus.o_valid <= vld_pipe[2];
         if (vld_pipe[2]) begin
            bus.o_pixel <= pix_n;
            bus.o_sat   <= sat_n;
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_prog_filter.sv
// Directed + randomized bench for conv3x3_prog_filter against an arithmetic reference
// model; expected results are queued per cycle and compared four cycles later.
module tb_conv3x3_prog_filter;
   localparam int PIX_W   = 4;
   localparam int COEF_W  = 4;
   localparam int ACC_W   = PIX_W + COEF_W + 4;
   localparam int SHIFT_W = 4;
   localparam int MAXP    = (1 << PIX_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   conv3x3_prog_filter_if #(.PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)) bus ();

   conv3x3_prog_filter #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int pix;
      bit sat;
   } exp_t;

   exp_t pq[$];
   int   act[9];
   int   shd[9];
   int   kern[9];
   int   last_pix;
   bit   last_sat;
   int   checks = 0;
   int   errors = 0;

   function automatic int floor_div(input int a, input int d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic logic [9*PIX_W-1:0] pk9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
      logic [9*PIX_W-1:0] w;
      int p[9];
      p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(p[k]);
      return w;
   endfunction

   // Reference: plain integer dot product, then the normalisation rule, then the clamp.
   task automatic ref_out(input logic [9*PIX_W-1:0] px, input int mode, input int sh,
                          output int p, output bit sat);
      int sum = 0;
      int r;
      for (int k = 0; k < 9; k++) sum += int'(px[k*PIX_W +: PIX_W]) * act[k];
      case (mode)
         0:       r = floor_div(sum, 1 << sh);
         2:       r = ((sum < 0) ? -sum : sum) / (1 << sh);
         default: r = (sum < 0) ? 0 : sum / 9;
      endcase
      sat = 1'b0;
      p = r;
      if (r < 0)         begin p = 0;    sat = 1'b1; end
      else if (r > MAXP) begin p = MAXP; sat = 1'b1; end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      e.v = 1'b0; e.pix = 0; e.sat = 1'b0;
      if (pq.size() == 4) begin
         e = pq.pop_front();
         if (e.v) begin
            last_pix = e.pix;
            last_sat = e.sat;
         end
      end
      chk("o_valid", 16'(bus.o_valid), 16'(e.v));
      chk("o_pixel", 16'(bus.o_pixel), 16'(last_pix));
      chk("o_sat",   16'(bus.o_sat),   16'(last_sat));
   endtask

   task automatic cyc(input bit v, input logic [9*PIX_W-1:0] px, input int mode, input int sh,
                      input bit we = 1'b0, input int addr = 0, input int data = 0, input bit commit = 1'b0);
      exp_t e;
      bus.i_valid       = v;
      bus.i_pixels      = px;
      bus.i_mode        = mode[1:0];
      bus.i_shift       = sh[SHIFT_W-1:0];
      bus.i_coef_we     = we;
      bus.i_coef_addr   = addr[3:0];
      bus.i_coef_data   = data[COEF_W-1:0];
      bus.i_coef_commit = commit;
      e.v = v && reset_n;
      e.pix = 0;
      e.sat = 1'b0;
      if (e.v) ref_out(px, mode, sh, e.pix, e.sat);
      pq.push_back(e);
      if (reset_n) begin
         if (we && addr <= 8) shd[addr] = data;
         if (commit) act = shd;
      end
      tick();
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      pq.delete();
      for (int k = 0; k < 9; k++) begin act[k] = 1; shd[k] = 1; end
      last_pix = 0;
      last_sat = 1'b0;
      #1;
      chk("rst_o_valid", 16'(bus.o_valid), 16'd0);
      chk("rst_o_pixel", 16'(bus.o_pixel), 16'd0);
      chk("rst_o_sat",   16'(bus.o_sat),   16'd0);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 0, 0);
      reset_n = 1'b1;
   endtask

   task automatic load(input int k9[9]);
      for (int t = 0; t < 9; t++) cyc(1'b0, '0, 0, 0, 1'b1, t, k9[t]);
      cyc(1'b0, '0, 0, 0, 1'b0, 0, 0, 1'b1);
   endtask

   initial begin
      logic [9*PIX_W-1:0] px;
      int d;
      int sh;
      bus.i_valid = 1'b0; bus.i_pixels = '0; bus.i_mode = '0; bus.i_shift = '0;
      bus.i_coef_we = 1'b0; bus.i_coef_addr = '0; bus.i_coef_data = '0; bus.i_coef_commit = 1'b0;
      #2;
      do_reset(2);

      // Default kernel, mean of an all-15 window, continuous stream.
      for (int i = 0; i < 20; i++) cyc(1'b1, pk9(15, 15, 15, 15, 15, 15, 15, 15, 15), 1, 0);
      repeat (4) cyc(1'b0, '0, 0, 0);

      // Sharpen kernel.
      kern = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      load(kern);
      cyc(1'b1, pk9(0, 2, 0, 2, 10, 2, 0, 2, 0), 0, 0);
      cyc(1'b1, pk9(0, 0, 0, 0, 3, 0, 0, 0, 0), 0, 0);
      repeat (4) cyc(1'b0, '0, 0, 0);

      // Sobel-x, abs+shift then arithmetic shift.
      kern = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
      load(kern);
      cyc(1'b1, pk9(12, 0, 0, 12, 0, 0, 12, 0, 0), 2, 2);
      cyc(1'b1, pk9(12, 0, 0, 12, 0, 0, 12, 0, 0), 0, 2);
      cyc(1'b1, pk9(12, 0, 0, 12, 0, 0, 12, 0, 0), 0, 15);
      cyc(1'b1, pk9(0, 0, 15, 0, 0, 15, 0, 0, 15), 0, 12);
      repeat (4) cyc(1'b0, '0, 0, 0);

      // Commit timing: all-ones active, all-zero shadow, commit mid-stream.
      kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      load(kern);
      for (int t = 0; t < 9; t++) cyc(1'b0, '0, 0, 0, 1'b1, t, 0);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, pk9(8, 8, 8, 8, 8, 8, 8, 8, 8), 1, 0, 1'b0, 0, 0, i == 3);
      cyc(1'b1, pk9(8, 8, 8, 8, 8, 8, 8, 8, 8), 1, 0, 1'b1, 4, 2, 1'b1);
      cyc(1'b1, pk9(8, 8, 8, 8, 8, 8, 8, 8, 8), 1, 0);
      repeat (4) cyc(1'b0, '0, 0, 0);

      // Reset with three windows in flight.
      for (int i = 0; i < 3; i++) cyc(1'b1, pk9(8, 8, 8, 8, 8, 8, 8, 8, 8), 0, 0);
      do_reset(2);
      cyc(1'b1, pk9(15, 15, 15, 15, 15, 15, 15, 15, 15), 1, 0);
      repeat (5) cyc(1'b0, '0, 0, 0);

      // Out-of-range write, then per-window mode/shift changes.
      cyc(1'b0, '0, 0, 0, 1'b1, 12, -3);
      cyc(1'b0, '0, 0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 9; k++) px[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, MAXP));
         cyc(1'b1, px, i % 4, i % 3);
      end

      // Randomized traffic with random kernel writes and commits.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 9; k++) px[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, MAXP));
         d  = int'($urandom_range(0, 15)) - 8;
         sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
         cyc($urandom_range(0, 3) != 0, px, int'($urandom_range(0, 3)), sh,
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), d, $urandom_range(0, 7) == 0);
      end
      repeat (6) cyc(1'b0, '0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
